// File: rtl/excp_ctrl.sv
// Exception/interrupt controller: synchronises IRQ lines, arbitrates
// interrupt/syscall/eret and sequences flush then redirect.
module excp_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  intr_ext,
  input  logic        intimer,
  input  logic [31:0] status,
  input  logic [31:0] epc,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_syscall,
  input  logic        id_eret,
  output logic [5:0]  intr,
  output logic [31:0] excptype,
  output logic [31:0] excpc,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [31:0] CODE_INT  = 32'h0000_0004;
  localparam logic [31:0] CODE_SYS  = 32'h0000_0100;
  localparam logic [31:0] CODE_ERET = 32'h0000_0200;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    REDIRECT
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [5:0]  pending;
  logic        int_req;
  logic        ev;
  logic [31:0] ev_code;
  logic        unused_status;

  assign unused_status = ^{status[31:16], status[9:2]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], intr_ext};
    end
  end

  assign intr = {sync_q[SYNC_STAGES-1][5:1],
                 sync_q[SYNC_STAGES-1][0] | intimer};

  assign pending = intr & status[15:10];
  assign int_req = status[0] & ~status[1] & (|pending);

  // Interrupt outranks syscall; syscall outranks eret.
  always_comb begin
    ev_code = CODE_ERET;
    if (int_req) begin
      ev_code = CODE_INT;
    end else if (id_syscall) begin
      ev_code = CODE_SYS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    ev       = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    unique case (state)
      IDLE: begin
        if (id_valid && (int_req || id_syscall || id_eret)) begin
          ev      = 1'b1;
          state_n = TAKE;
        end
      end
      TAKE: begin
        flush   = 1'b1;
        stall   = 1'b1;
        state_n = REDIRECT;
      end
      REDIRECT: begin
        redirect = 1'b1;
        stall    = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // epc is sampled in TAKE so an eret sees the CP0 value after update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      excptype    <= '0;
      excpc       <= '0;
      redirect_pc <= '0;
    end else begin
      excptype <= ev ? ev_code : 32'h0;
      if (ev) begin
        excpc <= id_pc;
      end
      if (state == TAKE) begin
        redirect_pc <= (excptype == CODE_ERET) ? epc : HANDLER_ADDR;
      end
    end
  end

endmodule
